// File: rtl/lru_pkg.sv
// Shared definitions for the LRU tracker: request opcodes, FSM states and the
// pairwise-order helpers used to pick a victim and to update a set's LRU bits.
package lru_pkg;

  localparam int MAX_WAYS  = 8;
  localparam int MAX_WAY_W = 3;
  localparam int MAX_PAIR  = MAX_WAYS * (MAX_WAYS - 1) / 2;

  typedef enum logic [1:0] {
    OP_QUERY = 2'b00,
    OP_TOUCH = 2'b01,
    OP_INVAL = 2'b10,
    OP_ALIAS = 2'b11
  } lru_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } lru_state_e;

  // Bit position of the "way i more recent than way j" flag, i < j.
  function automatic int pair_idx(input int i, input int j, input int ways);
    return i * ways - i * (i + 1) / 2 + (j - i - 1);
  endfunction

  // A way is LRU when every pair says the other way is more recent.
  function automatic logic [MAX_WAY_W-1:0] victim_sel(input logic [MAX_PAIR-1:0] st,
                                                      input int ways);
    logic                 found;
    logic                 ok;
    logic [MAX_WAY_W-1:0] v_out;
    found = 1'b0;
    v_out = '0;
    for (int v = 0; v < MAX_WAYS; v++) begin
      ok = (v < ways);
      for (int k = 0; k < MAX_WAYS; k++) begin
        if (k < ways) begin
          if (k > v) begin
            if (st[5'(pair_idx(v, k, ways))]) ok = 1'b0;
          end else if (k < v) begin
            if (!st[5'(pair_idx(k, v, ways))]) ok = 1'b0;
          end
        end
      end
      if (ok && !found) begin
        found = 1'b1;
        v_out = MAX_WAY_W'(v);
      end
    end
    return v_out;
  endfunction

  // Touch makes the way newer than every other way; invalidate makes it older.
  function automatic logic [MAX_PAIR-1:0] next_state_calc(input logic [MAX_PAIR-1:0]  st,
                                                          input logic [1:0]           op,
                                                          input logic [MAX_WAY_W-1:0] way,
                                                          input int                   ways);
    logic [MAX_PAIR-1:0] nxt;
    logic                newer;
    nxt   = st;
    newer = (op == OP_TOUCH);
    if (op == OP_TOUCH || op == OP_INVAL) begin
      for (int i = 0; i < MAX_WAYS; i++) begin
        for (int j = 0; j < MAX_WAYS; j++) begin
          if (i < j && j < ways) begin
            if (int'(way) == i) nxt[5'(pair_idx(i, j, ways))] = newer;
            else if (int'(way) == j) nxt[5'(pair_idx(i, j, ways))] = !newer;
          end
        end
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lru_pair_logic.sv
// Combinational core of the tracker: victim of a set's pair bits and the
// pair bits after applying one query/touch/invalidate.
module lru_pair_logic
  import lru_pkg::*;
#(
  parameter int  WAYS   = 4,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int PAIR_W = WAYS * (WAYS - 1) / 2
) (
  input  logic [PAIR_W-1:0] state,
  input  logic [1:0]        op,
  input  logic [WAY_W-1:0]  way,
  output logic [WAY_W-1:0]  victim,
  output logic [PAIR_W-1:0] next_state
);

  logic [MAX_PAIR-1:0]  st_ext;
  logic [MAX_PAIR-1:0]  nxt_ext;
  logic [MAX_WAY_W-1:0] way_ext;
  logic [MAX_WAY_W-1:0] vic_ext;
  logic                 unused_bits;

  // Helpers work at the largest supported associativity; pad and trim here.
  always_comb begin
    st_ext                = '0;
    st_ext[PAIR_W-1:0]    = state;
    way_ext               = '0;
    way_ext[WAY_W-1:0]    = way;
  end

  assign vic_ext     = victim_sel(st_ext, WAYS);
  assign nxt_ext     = next_state_calc(st_ext, op, way_ext, WAYS);
  assign victim      = vic_ext[WAY_W-1:0];
  assign next_state  = nxt_ext[PAIR_W-1:0];
  assign unused_bits = ^{nxt_ext, vic_ext};

endmodule

// File: rtl/lru_tracker.sv
// Per-set pairwise LRU tracker: init sweep, two-stage read/modify/write
// pipeline with same-set forwarding, victim reported two cycles after accept.
module lru_tracker
  import lru_pkg::*;
#(
  parameter int  WAYS   = 4,
  parameter int  SETS   = 16,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int SET_W  = $clog2(SETS),
  localparam int PAIR_W = WAYS * (WAYS - 1) / 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  output logic             rsp_valid,
  output logic [SET_W-1:0] rsp_set,
  output logic [WAY_W-1:0] rsp_victim,
  output logic             init_done
);

  // Handshake: a request transfers on any rising edge where req_valid and
  // req_ready are both high; responses are single-cycle pulses with no ready.

  lru_state_e        state;
  lru_state_e        state_nxt;
  logic [SET_W-1:0]  sweep_cnt;
  logic              sweep_last;
  logic [PAIR_W-1:0] mem [SETS];

  logic              accept;
  logic              fwd_hit;
  logic [PAIR_W-1:0] rd_state;

  logic              s1_valid;
  logic [SET_W-1:0]  s1_set;
  logic [1:0]        s1_op;
  logic [WAY_W-1:0]  s1_way;
  logic [PAIR_W-1:0] s1_state;

  logic [WAY_W-1:0]  s2_victim;
  logic [PAIR_W-1:0] s2_next;

  assign sweep_last = (sweep_cnt == SET_W'(SETS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (sweep_last) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) sweep_cnt <= sweep_cnt + SET_W'(1);
    end
  end

  assign req_ready = (state == ST_RUN);
  assign init_done = (state == ST_RUN);
  assign accept    = req_valid && req_ready;

  // The array write for S2 lands at the end of this cycle, so a same-set
  // read in S1 must take S2's result instead of the array.
  assign fwd_hit  = s1_valid && (s1_set == req_set);
  assign rd_state = fwd_hit ? s2_next : mem[req_set];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) mem[sweep_cnt] <= '0;
      else if (s1_valid)    mem[s1_set]    <= s2_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_set   <= req_set;
        s1_op    <= req_op;
        s1_way   <= req_way;
        s1_state <= rd_state;
      end
    end
  end

  lru_pair_logic #(.WAYS(WAYS)) u_pair_logic (
    .state      (s1_state),
    .op         (s1_op),
    .way        (s1_way),
    .victim     (s2_victim),
    .next_state (s2_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_set    <= '0;
      rsp_victim <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_set    <= s1_set;
        rsp_victim <= s2_victim;
      end
    end
  end

endmodule
